// File: rtl/speed_controller_mc.sv
// speed_controller_mc -- multi-channel motor speed controller.
// Per channel: duty-cycle PWM drive and shaft-speed measurement by counting
// encoder rising edges over a shared gate window. Single system clock; the
// PWM rate comes from an internal prescaler.
// Optional stall detection is compiled in by defining SPEEDCTL_STALL_DETECT_EN;
// without it Stall is constant 0 and PWM is never forced off.

module speed_controller_mc #(
   parameter int CHANNELS      = 2,
   parameter int DUTY_W        = 8,
   parameter int RATE_W        = 8,
   parameter int PWM_DIV       = 10,
   parameter int GATE_CYCLES   = 5120,
   parameter int STALL_WINDOWS = 4
) (
   input  logic                       CLK,
   input  logic                       RST_n,
   input  logic [CHANNELS*DUTY_W-1:0] Duty_In,
   input  logic [CHANNELS-1:0]        AngularEncoder,
   output logic [CHANNELS-1:0]        PWM_Out,
   output logic [CHANNELS*RATE_W-1:0] Rate,
   output logic                       Rate_Valid,
   output logic [CHANNELS-1:0]        Stall
);

   // ------------------------------------------------------------------
   // Parameter legality (elaboration time only)
   // ------------------------------------------------------------------
   if (PWM_DIV < 1) begin : g_chk_pwm_div
      $error("speed_controller_mc: PWM_DIV must be >= 1");
   end
   if (GATE_CYCLES < 2) begin : g_chk_gate
      $error("speed_controller_mc: GATE_CYCLES must be >= 2");
   end
   if (STALL_WINDOWS < 1) begin : g_chk_stall
      $error("speed_controller_mc: STALL_WINDOWS must be >= 1");
   end

   // ------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------
   localparam int PRE_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
   localparam int GATE_W = $clog2(GATE_CYCLES);

   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PWM_DIV - 1);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   // PWM counter tops out at 2^DUTY_W-2 so that duty 2^DUTY_W-1 is always high
   localparam logic [DUTY_W-1:0] PWM_LAST  = {{(DUTY_W-1){1'b1}}, 1'b0};
   localparam logic [RATE_W-1:0] RATE_MAX  = '1;

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   // PWM timebase
   logic [PRE_W-1:0]    r_pwm_pre;
   logic [DUTY_W-1:0]   r_pwm_cnt;
   logic                w_pwm_step;
   logic                w_period_start;

   // Per-channel PWM
   logic [DUTY_W-1:0]   w_duty_in [CHANNELS];
   logic [DUTY_W-1:0]   r_duty    [CHANNELS];
   logic [CHANNELS-1:0] r_pwm_out;
   logic [CHANNELS-1:0] w_force_off;

   // Encoder front end
   logic [CHANNELS-1:0] r_enc_s1;
   logic [CHANNELS-1:0] r_enc_s2;
   logic [CHANNELS-1:0] r_enc_prev;
   logic [CHANNELS-1:0] r_enc_edge;

   // Rate measurement
   logic [GATE_W-1:0]   r_gate;
   logic                w_gate_last;
   logic [RATE_W-1:0]   r_edge_cnt   [CHANNELS];
   logic [RATE_W-1:0]   w_count_next [CHANNELS];
   logic [RATE_W-1:0]   r_rate       [CHANNELS];
   logic                r_rate_valid;

   // ------------------------------------------------------------------
   // Bus packing
   // ------------------------------------------------------------------
   for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
      assign w_duty_in[g]              = Duty_In[g*DUTY_W +: DUTY_W];
      assign Rate[g*RATE_W +: RATE_W]  = r_rate[g];
   end

   // ------------------------------------------------------------------
   // PWM timebase
   // ------------------------------------------------------------------
   assign w_pwm_step     = (r_pwm_pre == PRE_LAST);
   // The step that wraps the counter back to 0 begins a new period
   assign w_period_start = w_pwm_step && (r_pwm_cnt == PWM_LAST);

   // Prescaler: one PWM step every PWM_DIV clocks
   // NOTE: sequential state is assigned with non-blocking (<=) so every flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n)          r_pwm_pre <= '0;
      else if (w_pwm_step) r_pwm_pre <= '0;
      else                 r_pwm_pre <= r_pwm_pre + PRE_W'(1);
   end

   // Shared PWM counter: 0 .. 2^DUTY_W-2, advances on each step
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_pwm_cnt <= '0;
      end else if (w_pwm_step) begin
         if (r_pwm_cnt == PWM_LAST) r_pwm_cnt <= '0;
         else                       r_pwm_cnt <= r_pwm_cnt + DUTY_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Per-channel PWM
   // ------------------------------------------------------------------
   // Duty latch: sampled only as a period starts so mid-period changes wait
   // NOTE: r_duty is a small per-channel flop array rather than a RAM, so it takes the async reset like any other register.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         for (int i = 0; i < CHANNELS; i++) r_duty[i] <= '0;
      end else if (w_period_start) begin
         for (int i = 0; i < CHANNELS; i++) r_duty[i] <= w_duty_in[i];
      end
   end

   // Registered compare; a stalled channel is held low
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_pwm_out <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++)
            r_pwm_out[i] <= (r_pwm_cnt < r_duty[i]) && !w_force_off[i];
      end
   end

   // ------------------------------------------------------------------
   // Encoder front end
   // ------------------------------------------------------------------
   // Two-flop synchronizer followed by a registered rising-edge detect
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_enc_s1   <= '0;
         r_enc_s2   <= '0;
         r_enc_prev <= '0;
         r_enc_edge <= '0;
      end else begin
         r_enc_s1   <= AngularEncoder;
         r_enc_s2   <= r_enc_s1;
         r_enc_prev <= r_enc_s2;
         r_enc_edge <= r_enc_s2 & ~r_enc_prev;
      end
   end

   // ------------------------------------------------------------------
   // Rate measurement
   // ------------------------------------------------------------------
   assign w_gate_last = (r_gate == GATE_LAST);

   // Edge count including this cycle's edge, saturating at RATE_MAX
   // NOTE: each always_comb output is given a default before any condition, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         w_count_next[i] = r_edge_cnt[i];
         if (r_enc_edge[i] && (r_edge_cnt[i] != RATE_MAX))
            w_count_next[i] = r_edge_cnt[i] + RATE_W'(1);
      end
   end

   // Gate window counter: 0 .. GATE_CYCLES-1
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n)           r_gate <= '0;
      else if (w_gate_last) r_gate <= '0;
      else                  r_gate <= r_gate + GATE_W'(1);
   end

   // Edge counters restart each window; the last cycle's edge goes into Rate
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_edge_cnt[i] <= '0;
            r_rate[i]     <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (w_gate_last) begin
               r_edge_cnt[i] <= '0;
               r_rate[i]     <= w_count_next[i];
            end else begin
               r_edge_cnt[i] <= w_count_next[i];
            end
         end
      end
   end

   // Rate_Valid pulses together with the new Rate
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) r_rate_valid <= 1'b0;
      else        r_rate_valid <= w_gate_last;
   end

   // ------------------------------------------------------------------
   // Stall detection
   // ------------------------------------------------------------------
`ifdef SPEEDCTL_STALL_DETECT_EN
   localparam int STALL_W = $clog2(STALL_WINDOWS + 1);
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_WINDOWS);

   logic [STALL_W-1:0]  r_stall_cnt      [CHANNELS];
   logic [STALL_W-1:0]  w_stall_cnt_next [CHANNELS];
   logic [CHANNELS-1:0] w_stall_clear;
   logic [CHANNELS-1:0] r_stall;

   // Consecutive idle-while-driven windows; cleared by a zero-duty period start
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         w_stall_clear[i]    = w_period_start && (w_duty_in[i] == '0);
         w_stall_cnt_next[i] = r_stall_cnt[i];
         if (w_stall_clear[i]) begin
            w_stall_cnt_next[i] = '0;
         end else if (w_gate_last) begin
            if ((w_count_next[i] == '0) && (r_duty[i] != '0)) begin
               if (r_stall_cnt[i] != STALL_MAX)
                  w_stall_cnt_next[i] = r_stall_cnt[i] + STALL_W'(1);
            end else begin
               w_stall_cnt_next[i] = '0;
            end
         end
      end
   end

   // Stall flag sets with the Rate update that completes the idle run
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         for (int i = 0; i < CHANNELS; i++) r_stall_cnt[i] <= '0;
         r_stall <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_stall_cnt[i] <= w_stall_cnt_next[i];
            if (w_stall_clear[i])
               r_stall[i] <= 1'b0;
            else if (w_gate_last && (w_stall_cnt_next[i] == STALL_MAX))
               r_stall[i] <= 1'b1;
         end
      end
   end

   assign w_force_off = r_stall;
   assign Stall       = r_stall;
`else
   assign w_force_off = '0;
   assign Stall       = '0;
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign PWM_Out    = r_pwm_out;
   assign Rate_Valid = r_rate_valid;

endmodule

// File: tb/tb_speed_controller_mc.sv
// tb_speed_controller_mc -- self-checking bench for speed_controller_mc.
// Rate results are predicted into a queue when encoder stimulus is set and
// compared by a monitor on each Rate_Valid; PWM high-time predictions are
// queued when duty is driven and compared when a period has been measured.
// Stall expectations follow SPEEDCTL_STALL_DETECT_EN.

module tb_speed_controller_mc;

   localparam int CH        = 2;
   localparam int DUTY_W    = 8;
   localparam int RATE_W    = 8;
   localparam int PWM_DIV   = 1;
   localparam int GATE      = 1000;
   localparam int STALL_WIN = 3;
   localparam int PERIOD    = (1 << DUTY_W) - 1;   // PWM period in clocks (PWM_DIV=1)

`ifdef SPEEDCTL_STALL_DETECT_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   typedef struct {
      logic [CH*RATE_W-1:0] rate;
      logic [CH-1:0]        stall;
   } rate_exp_t;

   logic                  clk;
   logic                  rst_n;
   logic [CH*DUTY_W-1:0]  duty_in;
   logic [CH-1:0]         enc;
   logic [CH-1:0]         pwm_out;
   logic [CH*RATE_W-1:0]  rate;
   logic                  rate_valid;
   logic [CH-1:0]         stall;

   rate_exp_t rate_q [$];
   int        pwm_q  [$];
   int        half_period [CH];
   int        n_checks = 0;
   int        n_fail   = 0;

   // monitor state
   logic      mon_prev_valid = 1'b0;
   bit        mon_have_last  = 1'b0;
   int        mon_cyc        = 0;
   int        mon_last       = 0;

   speed_controller_mc #(
      .CHANNELS      (CH),
      .DUTY_W        (DUTY_W),
      .RATE_W        (RATE_W),
      .PWM_DIV       (PWM_DIV),
      .GATE_CYCLES   (GATE),
      .STALL_WINDOWS (STALL_WIN)
   ) dut (
      .CLK            (clk),
      .RST_n          (rst_n),
      .Duty_In        (duty_in),
      .AngularEncoder (enc),
      .PWM_Out        (pwm_out),
      .Rate           (rate),
      .Rate_Valid     (rate_valid),
      .Stall          (stall)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic set_duty(input int ch, input logic [DUTY_W-1:0] val);
      duty_in[ch*DUTY_W +: DUTY_W] = val;
   endtask

   task automatic push_rate(input logic [RATE_W-1:0] r0, input logic [RATE_W-1:0] r1,
                            input logic [CH-1:0] st);
      rate_exp_t e;
      e.rate  = {r1, r0};
      e.stall = st;
      rate_q.push_back(e);
   endtask

   // Wait (bounded) for the next Rate_Valid pulse, sampled at negedge
   task automatic wait_rv(input string tag);
      int n    = 0;
      bit seen = 1'b0;
      while (!seen && n < 2*GATE + 10) begin
         @(negedge clk);
         n++;
         seen = rate_valid;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   // Count PWM high samples over one full period and compare with the queue
   task automatic measure_pwm(input int ch, input string tag);
      int hi = 0;
      int expv;
      for (int i = 0; i < PERIOD; i++) begin
         @(negedge clk);
         hi += int'(pwm_out[ch]);
      end
      expv = pwm_q.pop_front();
      check(tag, 32'(hi), 32'(expv));
   endtask

   // Encoder pins: each toggles every half_period[c] clocks, 0 = idle low
   initial begin
      int cnt [CH];
      foreach (cnt[c]) cnt[c] = 0;
      enc = '0;
      forever begin
         @(negedge clk);
         for (int c = 0; c < CH; c++) begin
            if (half_period[c] == 0) begin
               enc[c] = 1'b0;
               cnt[c] = 0;
            end else begin
               cnt[c]++;
               if (cnt[c] >= half_period[c]) begin
                  enc[c] = ~enc[c];
                  cnt[c] = 0;
               end
            end
         end
      end
   end

   // Rate monitor: pulse width, pulse spacing, and scoreboard compare
   initial begin
      rate_exp_t e;
      forever begin
         @(negedge clk);
         mon_cyc++;
         if (!rst_n) begin
            mon_have_last = 1'b0;
         end else if (rate_valid) begin
            check("rv_single_cycle", 32'(mon_prev_valid), 32'd0);
            if (mon_have_last) check("rv_spacing", 32'(mon_cyc - mon_last), 32'(GATE));
            mon_have_last = 1'b1;
            mon_last      = mon_cyc;
            if (rate_q.size() > 0) begin
               e = rate_q.pop_front();
               check("rate", 32'(rate), 32'(e.rate));
               check("stall_at_rv", 32'(stall), 32'(e.stall));
            end
         end
         mon_prev_valid = rate_valid;
      end
   end

   // Main sequence
   initial begin
      int  n;
      bit  seen;
      bit  found;
      logic prev;
      int  hi_a;
      int  hi_b;

      rst_n       = 1'b0;
      duty_in     = '0;
      half_period = '{10, 25};
      set_duty(0, 8'd100);
      set_duty(1, 8'd0);

      // Reset state
      repeat (4) @(posedge clk);
      #1;
      check("reset_pwm",   32'(pwm_out),    32'd0);
      check("reset_rate",  32'(rate),       32'd0);
      check("reset_valid", 32'(rate_valid), 32'd0);
      check("reset_stall", 32'(stall),      32'd0);
      rst_n = 1'b1;

      // Steady encoder rates: first window discarded, then 50 / 20 per window
      wait_rv("rv_first_seen");
      @(posedge clk);
      push_rate(8'd50, 8'd20, 2'b00);
      push_rate(8'd50, 8'd20, 2'b00);
      wait_rv("rv_w2_seen");
      wait_rv("rv_w3_seen");

      // PWM high time: duty 100 on ch0, then 255 and 0 on ch1
      pwm_q.push_back(100);
      measure_pwm(0, "pwm_ch0_duty100");
      set_duty(1, 8'd255);
      pwm_q.push_back(PERIOD);
      repeat (2*PERIOD) @(negedge clk);
      measure_pwm(1, "pwm_ch1_duty255");
      set_duty(1, 8'd0);
      pwm_q.push_back(0);
      repeat (2*PERIOD) @(negedge clk);
      measure_pwm(1, "pwm_ch1_duty0");

      // Mid-period duty change: current period keeps 100, next gets 200
      pwm_q.push_back(100);
      prev  = pwm_out[0];
      found = 1'b0;
      for (int i = 0; i < 3*PERIOD && !found; i++) begin
         @(negedge clk);
         if (pwm_out[0] && !prev) found = 1'b1;
         prev = pwm_out[0];
      end
      check("pwm_rise_seen", 32'(found), 32'd1);
      hi_a = 1;
      for (int i = 2; i <= PERIOD; i++) begin
         @(negedge clk);
         hi_a += int'(pwm_out[0]);
         if (i == 50) begin
            set_duty(0, 8'd200);
            pwm_q.push_back(200);
         end
      end
      hi_b = 0;
      for (int i = 0; i < PERIOD; i++) begin
         @(negedge clk);
         hi_b += int'(pwm_out[0]);
      end
      check("pwm_period_keep", 32'(hi_a), 32'(pwm_q.pop_front()));
      check("pwm_period_next", 32'(hi_b), 32'(pwm_q.pop_front()));

      // Saturation: ch0 toggles every clock (500 edges/window) -> 255
      wait_rv("rv_pre_sat_seen");
      half_period[0] = 1;
      wait_rv("rv_sat_transition_seen");
      @(posedge clk);
      push_rate(8'd255, 8'd20, 2'b00);
      wait_rv("rv_sat_seen");

      // Mid-window reset, then idle encoders with duty 100 on ch0
      repeat (300) @(posedge clk);
      #1;
      half_period = '{0, 0};
      set_duty(0, 8'd100);
      set_duty(1, 8'd0);
      rst_n = 1'b0;
      #1;
      check("midrst_rate",  32'(rate),       32'd0);
      check("midrst_pwm",   32'(pwm_out),    32'd0);
      check("midrst_valid", 32'(rate_valid), 32'd0);
      check("midrst_stall", 32'(stall),      32'd0);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_rate(8'd0, 8'd0, 2'b00);
      push_rate(8'd0, 8'd0, 2'b00);
      push_rate(8'd0, 8'd0, {1'b0, STALL_EN});
      // The release cycle is clock 1; the first pulse lands in clock GATE+1
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 2*GATE) begin
         @(negedge clk);
         n++;
         seen = rate_valid;
      end
      check("rv_after_reset", 32'(n), 32'(GATE + 1));
      wait_rv("rv_idle2_seen");
      wait_rv("rv_idle3_seen");

      // A stalled channel drives no PWM
      pwm_q.push_back(STALL_EN ? 0 : 100);
      measure_pwm(0, "pwm_after_stall");

      // Encoder restored: stall stays set while duty is nonzero
      half_period[0] = 10;
      wait_rv("rv_restore1_seen");
      wait_rv("rv_restore2_seen");
      check("stall_held", 32'(stall[0]), 32'(STALL_EN));

      // Duty 0 clears the stall at the next period start
      set_duty(0, 8'd0);
      repeat (PERIOD + 45) @(negedge clk);
      check("stall_cleared", 32'(stall), 32'd0);
      pwm_q.push_back(0);
      measure_pwm(0, "pwm_ch0_duty0");

      check("rate_queue_drained", 32'(rate_q.size()), 32'd0);
      check("pwm_queue_drained",  32'(pwm_q.size()),  32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/speed_controller_mc.md
# speed_controller_mc

Multi-channel successor to the single-channel speed controller. Per channel it generates a duty-cycle PWM motor drive and measures shaft speed by counting angular-encoder rising edges over a fixed gate window. Everything runs on one system clock, with internal prescaling replacing the separate encoder and PWM clocks. It sits between the march/drive sequencer (which supplies duties) and the motor driver pins, and returns per-channel rate words to the sequencer.

## Interface
Parameters:
- CHANNELS, 2: number of independent motor channels.
- DUTY_W, 8: duty and PWM counter width.
- RATE_W, 8: rate word width.
- PWM_DIV, 10: system clocks per PWM counter step (≥1).
- GATE_CYCLES, 5120: system clocks per rate gate window (≥2).
- STALL_WINDOWS, 4: consecutive zero-edge windows that declare a stall (≥1).

Ports:
- CLK  in  1  system clock.
- RST_n  in  1  asynchronous, active-low reset.
- Duty_In  in  CHANNELS*DUTY_W  per-channel duty; channel i occupies bits [i*DUTY_W +: DUTY_W].
- AngularEncoder  in  CHANNELS  raw asynchronous encoder pins.
- PWM_Out  out  CHANNELS  PWM drive.
- Rate  out  CHANNELS*RATE_W  per-channel edges per window; same packing as Duty_In.
- Rate_Valid  out  1  one-cycle pulse when Rate updates (all channels update together).
- Stall  out  CHANNELS  stall flag; tied 0 when stall detection is compiled out.

## Operation
- Reset values:
  - Outputs: PWM_Out=0, Rate=0, Rate_Valid=0, Stall=0.
  - Internal: all prescalers, counters and duty latches are 0.
- PWM:
  - A shared prescaler emits a step every PWM_DIV clocks.
  - A shared counter runs 0..2^DUTY_W−2, advances on each step, and wraps to 0. The period is (2^DUTY_W−1)·PWM_DIV clocks.
  - Each channel latches Duty_In when the counter is 0 (period start). Mid-period duty changes do not take effect until the next period.
  - PWM_Out[i] is registered as (cnt < duty_latched[i]). Duty 0 gives a constant low output; duty 2^DUTY_W−1 gives a constant high output.
- Encoder:
  - Each input passes through a 2-flop synchronizer, then a registered rising-edge detect.
  - Each edge increments a per-channel counter that saturates at 2^RATE_W−1.
- Gate window:
  - A shared counter runs 0..GATE_CYCLES−1.
  - On the last cycle, every channel's Rate latches (count + edge in that cycle, saturated) and Rate_Valid pulses the following cycle together with the new Rate.
  - Edge counters restart at 0 for the next window; no edge is lost or double-counted at the window boundary.
- Reset asserted mid-operation: all state clears asynchronously. After deassertion the first window is a full GATE_CYCLES window.

## Timing
- Pin to counted edge: 3 clocks (2 sync flops plus edge register).
- Rate/Rate_Valid are registered and appear 1 clock after the last window cycle.
- Duty latch to PWM_Out change: 1 clock after the period-start step.
- Maximum countable encoder rate is 1 rising edge per 2 clocks; pulses shorter than 1 clock may be missed.

## Configuration
- Macro SPEEDCTL_STALL_DETECT_EN.
- Defined:
  - Each channel keeps a counter of consecutive windows with zero edges while duty_latched≠0. Any window with ≥1 edge, or with duty_latched=0, resets it.
  - When the counter reaches STALL_WINDOWS, Stall[i] sets in the same cycle Rate updates, and PWM_Out[i] is forced 0 from the next clock.
  - Stall[i] clears only at a period start where Duty_In[i]=0. The stall counter clears at the same time.
- Undefined: no stall logic; Stall is constant 0 and PWM is never forced.

## Test plan
- CHANNELS=2, PWM_DIV=1, GATE_CYCLES=1000. Ch0 encoder toggles every 10 clk, ch1 every 25 clk → after the second window Rate ch0=50, ch1=20, with Rate_Valid a single-cycle pulse every 1000 clk.
- Duty ch0=100, PWM_DIV=1 → PWM_Out[0] high exactly 100 of every 255 clks. Duty 0 → never high; duty 255 → always high.
- Duty changed 100→200 mid-period → the current period keeps 100 high clocks; the next period has 200.
- RATE_W=8, encoder toggling every clock → Rate=255 (saturated, no wrap).
- With SPEEDCTL_STALL_DETECT_EN, STALL_WINDOWS=3, duty 100, encoder idle:
  - Stall[0]=1 at the third window's Rate_Valid, then PWM_Out[0]=0.
  - Restoring the encoder keeps Stall set; setting duty 0 clears it at the next period start.
- RST_n pulsed low mid-window → all outputs 0 immediately; the next Rate_Valid arrives GATE_CYCLES+1 clk after release.
